// File: rtl/fpu_issue_ctrl.sv
// Issue/writeback controller for the FP execution unit: single outstanding op,
// one-entry result buffer feeding writeback and forwarding, RAW hazard to decode.
module fpu_issue_ctrl #(
    parameter int TIMEOUT = 63
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_rd,
    input  logic [4:0]  req_rs1,
    input  logic [4:0]  req_rs2,
    input  logic        req_wr_en,
    input  logic        req_wr_f,
    input  logic [1:0]  req_rs_f,
    output logic        exe_enabled,
    input  logic        exe_completed,
    input  logic [31:0] exe_result,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [4:0]  wb_rd,
    output logic        wb_wr_en,
    output logic        wb_wr_f,
    output logic [31:0] wb_value,
    output logic        fwd_enabled,
    output logic        fwd_fenabled,
    output logic [4:0]  fwd_key,
    output logic [31:0] fwd_value,
    output logic        hazard,
    output logic        timeout_err
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [4:0]    r_rd;
    logic          r_wr_en, r_wr_f;
    logic [31:0]   r_value;
    logic          r_tmo;

    logic          w_accept, w_capture, w_expire;
    logic          w_dest_live, w_rs1_hit, w_rs2_hit;
    logic [CW:0]   w_cnt_inc;

    assign w_cnt_inc = {1'b0, r_cnt} + (CW+1)'(1);

    // Integer x0 is hardwired, so it can never be a true dependency.
    assign w_dest_live = r_wr_en && (r_wr_f || (r_rd != 5'd0));
    assign w_rs1_hit   = (req_rs1 == r_rd) && (req_rs_f[0] == r_wr_f);
    assign w_rs2_hit   = (req_rs2 == r_rd) && (req_rs_f[1] == r_wr_f);
    assign hazard      = ((r_state == S_ISSUE) || (r_state == S_WAIT)) &&
                         w_dest_live && (w_rs1_hit || w_rs2_hit);

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        exe_enabled = 1'b0;
        wb_valid    = 1'b0;
        w_capture   = 1'b0;
        w_expire    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                req_ready = !rst && !hazard;
                if (req_valid && req_ready) w_state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                exe_enabled = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // A stale-high completion is already cleared by the unit once it sees the enable.
                if (exe_completed) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_HOLD;
                end else if (w_cnt_inc == (CW+1)'(TIMEOUT)) begin
                    w_expire    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_HOLD: begin
                wb_valid  = 1'b1;
                req_ready = !rst && wb_ready && !hazard;
                if (wb_ready) w_state_nxt = (req_valid && req_ready) ? S_ISSUE : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_accept = req_valid && req_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_rd    <= '0;
            r_wr_en <= 1'b0;
            r_wr_f  <= 1'b0;
            r_value <= '0;
            r_tmo   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_rd    <= req_rd;
                r_wr_en <= req_wr_en;
                r_wr_f  <= req_wr_f;
            end
            if (r_state == S_ISSUE)
                r_cnt <= '0;
            else if (r_state == S_WAIT && !w_capture && !w_expire)
                r_cnt <= w_cnt_inc[CW-1:0];
            if (w_capture) r_value <= exe_result;
            if (w_expire)  r_tmo   <= 1'b1;
        end
    end

    assign wb_rd        = r_rd;
    assign wb_wr_en     = r_wr_en;
    assign wb_wr_f      = r_wr_f;
    assign wb_value     = r_value;
    assign fwd_fenabled = wb_valid && r_wr_en && r_wr_f;
    assign fwd_enabled  = wb_valid && r_wr_en && !r_wr_f && (r_rd != 5'd0);
    assign fwd_key      = r_rd;
    assign fwd_value    = r_value;
    assign timeout_err  = r_tmo;
endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Bench for fpu_issue_ctrl: event-level reference model, scoreboard of expected
// writebacks and a behavioural execution unit with random completion latency.
module tb_fpu_issue_ctrl;
    localparam int TO = 63;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, req_valid, req_ready;
    logic [4:0]  req_rd, req_rs1, req_rs2;
    logic        req_wr_en, req_wr_f;
    logic [1:0]  req_rs_f;
    logic        exe_enabled, exe_completed;
    logic [31:0] exe_result;
    logic        wb_valid, wb_ready;
    logic [4:0]  wb_rd;
    logic        wb_wr_en, wb_wr_f;
    logic [31:0] wb_value;
    logic        fwd_enabled, fwd_fenabled;
    logic [4:0]  fwd_key;
    logic [31:0] fwd_value;
    logic        hazard, timeout_err;

    fpu_issue_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .req_wr_en(req_wr_en), .req_wr_f(req_wr_f), .req_rs_f(req_rs_f),
        .exe_enabled(exe_enabled), .exe_completed(exe_completed), .exe_result(exe_result),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_wr_en(wb_wr_en),
        .wb_wr_f(wb_wr_f), .wb_value(wb_value), .fwd_enabled(fwd_enabled),
        .fwd_fenabled(fwd_fenabled), .fwd_key(fwd_key), .fwd_value(fwd_value),
        .hazard(hazard), .timeout_err(timeout_err)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [4:0]  rd;
        logic        wr_en;
        logic        wr_f;
        logic [31:0] val;
    } wb_t;

    wb_t         sb[$];
    int unsigned u_delay_q[$];
    logic [31:0] u_val_q[$];

    int unsigned cur_delay;
    logic [31:0] cur_val;
    bit          kick;

    // Reference model: one op at a time, described by accept cycle and capture flag.
    bit          m_started = 0, m_active = 0, m_captured = 0, m_tmo = 0, m_after_rst = 0;
    int          m_cyc = 0, m_acc = 0, m_waited = 0;
    logic [4:0]  m_rd = '0;
    bit          m_wr_en = 0, m_wr_f = 0;

    function automatic bit m_hazard();
        bit         dest_real;
        logic [4:0] rs;
        dest_real = m_wr_en && (m_wr_f || m_rd != 5'd0);
        if (!(m_active && !m_captured) || !dest_real) return 1'b0;
        for (int s = 0; s < 2; s++) begin
            rs = (s == 0) ? req_rs1 : req_rs2;
            if (rs == m_rd && req_rs_f[s] == m_wr_f) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit m_ready();
        return !rst && (!m_active || (m_captured && wb_ready)) && !m_hazard();
    endfunction

    initial begin
        bit acc;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_active = 0; m_captured = 0; m_tmo = 0; m_after_rst = 1;
                sb.delete(); u_delay_q.delete(); u_val_q.delete();
            end else begin
                acc = req_valid && m_ready();
                m_after_rst = 0;
                if (m_active && m_captured && wb_ready) begin
                    m_active = 0;
                end else if (m_active && !m_captured && m_cyc >= m_acc + 2) begin
                    if (exe_completed) m_captured = 1;
                    else begin
                        m_waited++;
                        if (m_waited == TO) begin
                            m_active = 0; m_tmo = 1;
                            void'(sb.pop_back());
                        end
                    end
                end
                if (acc) begin
                    m_active = 1; m_captured = 0; m_acc = m_cyc; m_waited = 0;
                    m_rd = req_rd; m_wr_en = req_wr_en; m_wr_f = req_wr_f;
                    sb.push_back('{req_rd, req_wr_en, req_wr_f, cur_val});
                    u_delay_q.push_back(cur_delay);
                    u_val_q.push_back(cur_val);
                end
            end
            m_cyc++;
            m_started = 1;
        end
    end

    // Behavioural execution unit: level completion that re-registers on enable.
    initial begin
        bit          en_s, u_pend;
        int unsigned u_cnt;
        logic [31:0] u_v;
        exe_completed = 1'b0;
        exe_result    = '0;
        u_pend = 0; u_cnt = 0; u_v = '0;
        forever begin
            @(negedge clk);
            en_s = exe_enabled;
            @(posedge clk);
            #2;
            if (rst) begin
                u_pend = 0;
                exe_completed = 1'b0;
            end else if (kick) begin
                exe_completed = 1'b1;
                exe_result    = 32'hBADC0DE5;
            end else if (en_s) begin
                if (u_delay_q.size() == 0) chk("spurious_enable", 64'(1), 64'(0));
                else begin
                    u_cnt = u_delay_q.pop_front();
                    u_v   = u_val_q.pop_front();
                    if (u_cnt == 0) begin
                        exe_completed = 1'b1; exe_result = u_v; u_pend = 0;
                    end else begin
                        exe_completed = 1'b0; u_pend = 1;
                    end
                end
            end else if (u_pend) begin
                u_cnt--;
                if (u_cnt == 0) begin
                    u_pend = 0; exe_completed = 1'b1; exe_result = u_v;
                end
            end
        end
    end

    // Monitor: per-cycle control checks plus scoreboard pop on each consumed writeback.
    initial begin
        wb_t e;
        forever begin
            @(negedge clk);
            if (m_started) begin
                chk("req_ready",   64'(req_ready),   64'(m_ready()));
                chk("exe_enabled", 64'(exe_enabled), 64'(m_active && m_cyc == m_acc + 1));
                chk("wb_valid",    64'(wb_valid),    64'(m_active && m_captured));
                chk("hazard",      64'(hazard),      64'(m_hazard()));
                chk("timeout_err", 64'(timeout_err), 64'(m_tmo));
                if (m_after_rst) begin
                    chk("rst_wb_rd",     64'(wb_rd),        64'(0));
                    chk("rst_wb_value",  64'(wb_value),     64'(0));
                    chk("rst_fwd_key",   64'(fwd_key),      64'(0));
                    chk("rst_fwd_value", 64'(fwd_value),    64'(0));
                    chk("rst_fwd_en",    64'(fwd_enabled),  64'(0));
                    chk("rst_fwd_fen",   64'(fwd_fenabled), 64'(0));
                end
                if (wb_valid && wb_ready) begin
                    if (sb.size() == 0) chk("sb_underflow", 64'(1), 64'(0));
                    else begin
                        e = sb.pop_front();
                        chk("wb_rd",        64'(wb_rd),        64'(e.rd));
                        chk("wb_wr_en",     64'(wb_wr_en),     64'(e.wr_en));
                        chk("wb_wr_f",      64'(wb_wr_f),      64'(e.wr_f));
                        chk("wb_value",     64'(wb_value),     64'(e.val));
                        chk("fwd_fenabled", 64'(fwd_fenabled), 64'(e.wr_en && e.wr_f));
                        chk("fwd_enabled",  64'(fwd_enabled),  64'(e.wr_en && !e.wr_f && e.rd != 5'd0));
                        chk("fwd_key",      64'(fwd_key),      64'(e.rd));
                        chk("fwd_value",    64'(fwd_value),    64'(e.val));
                    end
                end
            end
        end
    end

    task automatic step(input bit v, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input bit we, input bit wf,
                        input logic [1:0] rsf, input bit wbr, input int unsigned dly,
                        input logic [31:0] val);
        req_valid = v; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2;
        req_wr_en = we; req_wr_f = wf; req_rs_f = rsf; wb_ready = wbr;
        cur_delay = dly; cur_val = val;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 5'd0, 5'd0, 5'd0, 0, 0, 2'b00, 1, 0, 32'h0);
    endtask

    initial begin
        rst = 1'b1; kick = 0;
        req_valid = 0; req_rd = '0; req_rs1 = '0; req_rs2 = '0;
        req_wr_en = 0; req_wr_f = 0; req_rs_f = '0; wb_ready = 0;
        cur_delay = 0; cur_val = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;

        // fadd f3, then a dependent fadd (rs1 = f3) held until the HOLD cycle
        step(1, 5'd3, 5'd1, 5'd2, 1, 1, 2'b11, 1, 0, 32'h40400000);
        for (int i = 0; i < 3; i++) step(1, 5'd4, 5'd3, 5'd0, 1, 1, 2'b01, 1, 0, 32'h40800000);
        idle(6);

        // fcvt.w.s to x0; x0 sources never hazard; writeback stalled 5 cycles
        step(1, 5'd0, 5'd1, 5'd2, 1, 0, 2'b00, 1, 1, 32'h00000005);
        for (int i = 0; i < 3; i++) step(1, 5'd6, 5'd0, 5'd0, 1, 0, 2'b00, 0, 0, 32'h11);
        for (int i = 0; i < 5; i++) step(1, 5'd6, 5'd0, 5'd0, 1, 0, 2'b00, 0, 0, 32'h11);
        step(0, 5'd0, 5'd0, 5'd0, 0, 0, 2'b00, 1, 0, 32'h0);
        idle(4);

        // randomized traffic with a small register window to provoke collisions
        for (int i = 0; i < 3000; i++)
            step(($urandom % 4) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), ($urandom % 5) != 0, 1'($urandom % 2),
                 2'($urandom % 4), ($urandom % 3) != 0, $urandom_range(0, 5), $urandom);
        idle(12);

        // unit never completes: abort after TO wait cycles, sticky error
        step(1, 5'd7, 5'd0, 5'd0, 1, 1, 2'b00, 1, 1000, 32'h00001234);
        idle(TO + 6);
        step(1, 5'd9, 5'd0, 5'd0, 1, 1, 2'b00, 1, 0, 32'h3F800000);
        idle(6);

        // reset in the middle of WAIT, then a completion pulse that must be ignored
        step(1, 5'd8, 5'd0, 5'd0, 1, 1, 2'b00, 1, 10, 32'h55AA55AA);
        idle(3);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        kick = 1;
        idle(2);
        kick = 0;
        idle(4);
        step(1, 5'd10, 5'd0, 5'd0, 1, 0, 2'b00, 1, 2, 32'hCAFEF00D);
        idle(8);

        chk("sb_drained", 64'(sb.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
